serial_tx2: RTL and testbench



---
 rtl/serial_tx2.sv | 119 +++++++++++
 tb/tb_serial_tx2.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_tx2.sv
// serial_tx2: two-lane byte-to-serial transmitter. Each lane queues bytes in a
// small FIFO and sends them MSB first, filling idle, backpressured and post-reset slots with COM.
module serial_tx2 #(
  parameter int         DEPTH      = 4,
  parameter logic [7:0] COM        = 8'hBC,
  parameter int         ALIGN_SYMS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       push0,
  input  logic       push1,
  input  logic       almost_full_f0,
  input  logic       almost_full_f1,
  output logic       tx0,
  output logic       tx1,
  output logic       full0,
  output logic       full1,
  output logic       empty0,
  output logic       empty1,
  output logic       aligned
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(ALIGN_SYMS + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_SYMS - 1);

  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [AW-1:0] align_cnt_q, align_cnt_d;
  logic          aligned_q, aligned_d;
  logic          boundary;

  logic [7:0]    din [2];
  logic          push [2];
  logic          af [2];
  logic [7:0]    mem_q [2][DEPTH];
  logic [7:0]    sh_q [2], sh_d [2];
  logic [PW-1:0] rptr_q [2], rptr_d [2], wptr_q [2], wptr_d [2];
  logic [CW-1:0] cnt_q [2], cnt_d [2];
  logic          full_q [2], empty_q [2];
  logic          rd [2], wr [2];

  assign din[0]  = data0;
  assign din[1]  = data1;
  assign push[0] = push0;
  assign push[1] = push1;
  assign af[0]   = almost_full_f0;
  assign af[1]   = almost_full_f1;

  assign boundary = (bit_cnt_q == 3'd7);

  // Alignment run: one COM symbol completes per boundary until aligned, then the count holds.
  always_comb begin
    bit_cnt_d   = bit_cnt_q + 3'd1;
    align_cnt_d = align_cnt_q;
    aligned_d   = aligned_q;
    if (boundary && !aligned_q) begin
      align_cnt_d = align_cnt_q + AW'(1);
      if (align_cnt_q == ALIGN_LAST) aligned_d = 1'b1;
    end
  end

  // A push into a full FIFO is only taken when the same edge frees a slot.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      rd[l]     = boundary && aligned_q && !empty_q[l] && !af[l];
      wr[l]     = push[l] && (!full_q[l] || rd[l]);
      rptr_d[l] = rd[l] ? rptr_q[l] + PW'(1) : rptr_q[l];
      wptr_d[l] = wr[l] ? wptr_q[l] + PW'(1) : wptr_q[l];
      cnt_d[l]  = cnt_q[l] + CW'(wr[l]) - CW'(rd[l]);
      if (boundary) sh_d[l] = rd[l] ? mem_q[l][rptr_q[l]] : COM;
      else          sh_d[l] = {sh_q[l][6:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q   <= '0;
      align_cnt_q <= '0;
      aligned_q   <= 1'b0;
      for (int l = 0; l < 2; l++) begin
        sh_q[l]    <= COM;
        rptr_q[l]  <= '0;
        wptr_q[l]  <= '0;
        cnt_q[l]   <= '0;
        full_q[l]  <= 1'b0;
        empty_q[l] <= 1'b1;
      end
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      align_cnt_q <= align_cnt_d;
      aligned_q   <= aligned_d;
      for (int l = 0; l < 2; l++) begin
        sh_q[l]    <= sh_d[l];
        rptr_q[l]  <= rptr_d[l];
        wptr_q[l]  <= wptr_d[l];
        cnt_q[l]   <= cnt_d[l];
        full_q[l]  <= (cnt_d[l] == FULL_CNT);
        empty_q[l] <= (cnt_d[l] == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (wr[l]) mem_q[l][wptr_q[l]] <= din[l];
    end
  end

  assign tx0     = sh_q[0][7];
  assign tx1     = sh_q[1][7];
  assign full0   = full_q[0];
  assign full1   = full_q[1];
  assign empty0  = empty_q[0];
  assign empty1  = empty_q[1];
  assign aligned = aligned_q;
endmodule

// File: tb/tb_serial_tx2.sv
// Bench for serial_tx2: directed vector table, a full-FIFO push-on-pop sequence,
// and randomized traffic checked every cycle against a symbol-level queue model.
module tb_serial_tx2;
  localparam int         DEPTH = 4;
  localparam logic [7:0] COM   = 8'hBC;
  localparam int         ALIGN = 4;

  logic clk = 1'b0;
  logic rst, p0, p1, af0, af1;
  logic [7:0] d0, d1;
  logic tx0, tx1, full0, full1, empty0, empty1, aligned;

  int checks = 0;
  int errors = 0;

  serial_tx2 #(.DEPTH(DEPTH), .COM(COM), .ALIGN_SYMS(ALIGN)) dut (
    .clk(clk), .reset(rst),
    .data0(d0), .data1(d1), .push0(p0), .push1(p1),
    .almost_full_f0(af0), .almost_full_f1(af1),
    .tx0(tx0), .tx1(tx1), .full0(full0), .full1(full1),
    .empty0(empty0), .empty1(empty1), .aligned(aligned)
  );

  always #5 clk = ~clk;

  // Reference model: cycles since reset, the symbol on the wire per lane, and a byte queue per lane.
  int         mt = 0;
  logic [7:0] msym0 = 8'hBC, msym1 = 8'hBC;
  logic [7:0] mq0[$], mq1[$];

  function automatic logic [6:0] model_out();
    int k;
    k = 7 - (mt % 8);
    return {msym0[k], msym1[k], (mt >= 8 * ALIGN), (mq0.size() == 0), (mq1.size() == 0),
            (mq0.size() == DEPTH), (mq1.size() == DEPTH)};
  endfunction

  task automatic model_edge();
    bit bnd, al, pop0, pop1;
    int sz0, sz1;
    if (rst) begin
      mt = 0; msym0 = COM; msym1 = COM;
      mq0.delete(); mq1.delete();
    end else begin
      bnd = (mt % 8 == 7);
      al  = (mt >= 8 * ALIGN);
      sz0 = mq0.size();
      sz1 = mq1.size();
      pop0 = bnd && al && sz0 > 0 && !af0;
      pop1 = bnd && al && sz1 > 0 && !af1;
      if (pop0) msym0 = mq0.pop_front(); else if (bnd) msym0 = COM;
      if (pop1) msym1 = mq1.pop_front(); else if (bnd) msym1 = COM;
      if (p0 && (sz0 < DEPTH || pop0)) mq0.push_back(d0);
      if (p1 && (sz1 < DEPTH || pop1)) mq1.push_back(d1);
      mt++;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", nm, mt, got, exp);
    end
  endtask

  function automatic logic [6:0] dut_out();
    return {tx0, tx1, aligned, empty0, empty1, full0, full1};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", 64'(dut_out()), 64'(model_out()));
  endtask

  // exp packs {tx0, tx1, aligned, empty0, empty1, full0, full1} after n cycles with these inputs.
  typedef struct {
    int         n;
    logic       rst;
    logic       p0;
    logic [7:0] d0;
    logic       p1;
    logic [7:0] d1;
    logic       af0;
    logic [6:0] exp;
  } vec_t;

  vec_t vt[$];

  task automatic add(input int n, input logic r, input logic a, input logic [7:0] da,
                     input logic b, input logic [7:0] db, input logic f, input logic [6:0] e);
    vec_t v;
    v.n = n; v.rst = r; v.p0 = a; v.d0 = da; v.p1 = b; v.d1 = db; v.af0 = f; v.exp = e;
    vt.push_back(v);
  endtask

  logic [47:0] cap;
  logic [7:0]  fill [4];
  int          thr0, thr1;

  initial begin
    rst = 1'b1; p0 = 1'b0; p1 = 1'b0; af0 = 1'b0; af1 = 1'b0; d0 = '0; d1 = '0;

    add(0,  0, 0, 8'h00, 0, 8'h00, 0, 7'b1101100); // reset state, t=0
    add(1,  0, 0, 8'h00, 1, 8'h11, 0, 7'b0001000);
    add(1,  0, 0, 8'h00, 1, 8'h22, 0, 7'b1101000);
    add(1,  0, 0, 8'h00, 1, 8'h33, 0, 7'b1101000);
    add(1,  0, 0, 8'h00, 1, 8'h44, 0, 7'b1101001); // full1 after 4th push
    add(1,  0, 0, 8'h00, 1, 8'h55, 0, 7'b1101001); // 0x55 dropped
    add(26, 0, 0, 8'h00, 0, 8'h00, 0, 7'b0001001); // t=31, still aligning
    add(1,  0, 0, 8'h00, 0, 8'h00, 0, 7'b1111001); // t=32 aligned
    add(5,  0, 0, 8'h00, 0, 8'h00, 0, 7'b1111001); // t=37
    add(1,  0, 1, 8'hA5, 0, 8'h00, 0, 7'b0010001); // t=38
    add(2,  0, 0, 8'h00, 0, 8'h00, 0, 7'b1011000); // t=40 A5 MSB, 0x11 MSB
    add(1,  0, 0, 8'h00, 0, 8'h00, 0, 7'b0011000); // t=41
    add(7,  0, 0, 8'h00, 0, 8'h00, 0, 7'b1011000); // t=48 COM, 0x22
    add(2,  0, 0, 8'h00, 0, 8'h00, 0, 7'b1111000); // t=50
    add(1,  0, 1, 8'h3C, 0, 8'h00, 1, 7'b1010000); // t=51
    add(8,  0, 0, 8'h00, 0, 8'h00, 1, 7'b1110000); // t=59 COM held, 0x33
    add(5,  0, 0, 8'h00, 0, 8'h00, 1, 7'b1010100); // t=64
    add(8,  0, 0, 8'h00, 0, 8'h00, 0, 7'b0111100); // t=72 0x3C released
    add(1,  0, 0, 8'h00, 0, 8'h00, 0, 7'b0011100);
    add(1,  0, 1, 8'h01, 0, 8'h00, 0, 7'b1110100);
    add(1,  0, 1, 8'h02, 0, 8'h00, 0, 7'b1110100);
    add(1,  0, 1, 8'h03, 0, 8'h00, 0, 7'b1110100);
    add(1,  0, 1, 8'h04, 0, 8'h00, 0, 7'b1110110); // t=77 full0
    add(2,  0, 0, 8'h00, 0, 8'h00, 0, 7'b0010110); // t=79 boundary
    add(1,  0, 1, 8'h77, 0, 8'h00, 0, 7'b0110110); // push on pop keeps full0
    add(8,  0, 0, 8'h00, 0, 8'h00, 0, 7'b0110100); // t=88
    add(12, 0, 0, 8'h00, 0, 8'h00, 0, 7'b0110100); // t=100 mid-byte, 2 queued
    add(1,  1, 0, 8'h00, 0, 8'h00, 0, 7'b1101100); // reset mid-stream
    add(31, 0, 0, 8'h00, 0, 8'h00, 0, 7'b0001100);
    add(1,  0, 0, 8'h00, 0, 8'h00, 0, 7'b1111100);

    repeat (3) step();
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      rst = vt[i].rst; p0 = vt[i].p0; d0 = vt[i].d0;
      p1 = vt[i].p1; d1 = vt[i].d1; af0 = vt[i].af0; af1 = 1'b0;
      repeat (vt[i].n) step();
      chk($sformatf("vec%0d", i), 64'(dut_out()), 64'(vt[i].exp));
    end
    rst = 1'b0; p0 = 1'b0; p1 = 1'b0; af0 = 1'b0;

    // Fill lane 0, then push again in a popping boundary cycle.
    fill[0] = 8'hC3; fill[1] = 8'h5A; fill[2] = 8'h0F; fill[3] = 8'hE1;
    for (int i = 0; i < 4; i++) begin
      p0 = 1'b1; d0 = fill[i];
      step();
    end
    p0 = 1'b0;
    chk("full0_after_fill", 64'(full0), 64'(1));
    for (int i = 0; i < 8 && (mt % 8) != 7; i++) step();
    p0 = 1'b1; d0 = 8'h77;
    step();
    p0 = 1'b0;
    chk("full0_push_on_pop", 64'({full0, empty0}), 64'(2'b10));
    for (int i = 0; i < 48; i++) begin
      cap[47 - i] = tx0;
      step();
    end
    chk("tx0_order", 64'(cap), 64'(48'hC35A0FE177BC));
    chk("lane0_drained", 64'({full0, empty0}), 64'(2'b01));

    // Randomized traffic with varying push density and backpressure.
    thr0 = 2; thr1 = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 256 == 0) begin
        thr0 = $urandom_range(0, 5);
        thr1 = $urandom_range(0, 5);
      end
      rst = ($urandom_range(0, 499) == 0);
      p0  = ($urandom_range(0, 7) < thr0);
      p1  = ($urandom_range(0, 7) < thr1);
      d0  = 8'($urandom);
      d1  = 8'($urandom);
      af0 = ($urandom_range(0, 4) == 0);
      af1 = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
